// File: rtl/rf_spi_pkg.sv
// Shared types and constants for the RF SPI burst master.
package rf_spi_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_SHIFT,
      ST_HOLD,
      ST_GAP
   } state_t;

   localparam int SHORT_HDR_W = 8;
   localparam int LONG_HDR_W  = 16;

   // States in which chip select is asserted and SCK timing runs.
   function automatic logic is_framed(input state_t s);
      return (s == ST_SETUP) || (s == ST_SHIFT) || (s == ST_HOLD);
   endfunction

endpackage

// File: rtl/rf_spi_clkgen.sv
// Half-period tick generator for SCK; ticks alternate fall/rise phase starting with
// the end of the setup half-period, and the generator holds in reset while en is low.
module rf_spi_clkgen #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic rise_tick,
   output logic fall_tick
);

   localparam int HALF  = CLK_DIV / 2;
   localparam int CNT_W = (HALF > 1) ? $clog2(HALF) : 1;

   logic [CNT_W-1:0] cnt;
   logic             phase;
   logic             tick;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt   <= '0;
         phase <= 1'b0;
      end else if (!en) begin
         cnt   <= CNT_W'(HALF - 1);
         phase <= 1'b0;
      end else if (cnt == '0) begin
         cnt   <= CNT_W'(HALF - 1);
         phase <= ~phase;
      end else begin
         cnt <= cnt - 1'b1;
      end
   end

   assign tick      = en && (cnt == '0);
   assign rise_tick = tick && phase;
   assign fall_tick = tick && !phase;

endmodule

// File: rtl/rf_spi_burst.sv
// SPI mode-0 burst master for RF transceiver register access (short/long address).
// Build macro RF_SPI_INTR_ABORT_EN: intr high while the frame is active aborts it.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | req_ready high, cs high, waiting for a request
//   ST_SETUP | cs low, first bit on sdi, half SCK period before shifting
//   ST_SHIFT | one SCK period per bit, header then data
//   ST_HOLD  | cs still low for half a period after the last falling edge
//   ST_GAP   | cs high for CLK_DIV cycles; done/abort pulse on entry
module rf_spi_burst
   import rf_spi_pkg::*;
#(
   parameter int  CLK_DIV   = 4,
   parameter int  MAX_BYTES = 4,
   localparam int LEN_W     = $clog2(MAX_BYTES + 1)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic                   req_long,
   input  logic                   req_write,
   input  logic [9:0]             req_addr,
   input  logic [LEN_W-1:0]       req_len,
   input  logic [8*MAX_BYTES-1:0] wr_data,
   output logic [8*MAX_BYTES-1:0] rd_data,
   output logic                   done,
   output logic                   abort,
   input  logic                   intr,
   input  logic                   sdo,
   output logic                   sck,
   output logic                   sdi,
   output logic                   cs,
   output logic                   intr_out,
   output logic                   rst_n
);

   localparam int DATA_W = 8 * MAX_BYTES;
   localparam int SR_W   = LONG_HDR_W + DATA_W;
   localparam int BIT_W  = $clog2(SR_W + 1);
   localparam int GAP_W  = $clog2(CLK_DIV);

   state_t            state;
   logic [SR_W-1:0]   tx_sh;
   logic [SR_W-1:0]   tx_load;
   logic [BIT_W-1:0]  bits_left;
   logic [BIT_W-1:0]  data_bits;
   logic [BIT_W-1:0]  bits_load;
   logic [BIT_W-1:0]  dbits_load;
   logic [LEN_W-1:0]  len_eff;
   logic [LEN_W-1:0]  rx_idx;
   logic [2:0]        rx_bit;
   logic [6:0]        rx_sh;
   logic [DATA_W-1:0] rx_buf;
   logic [GAP_W-1:0]  gap_cnt;
   logic              clk_en;
   logic              rise_tick;
   logic              fall_tick;
   logic              abort_req;

   assign rst_n    = ~rst;
   assign intr_out = intr;
   assign clk_en   = is_framed(state);

`ifdef RF_SPI_INTR_ABORT_EN
   assign abort_req = intr;
`else
   assign abort_req = 1'b0;
`endif

   rf_spi_clkgen #(
      .CLK_DIV(CLK_DIV)
   ) u_clkgen (
      .clk      (clk),
      .rst      (rst),
      .en       (clk_en),
      .rise_tick(rise_tick),
      .fall_tick(fall_tick)
   );

   always_comb begin
      len_eff = req_len;
      if (req_len == '0) begin
         len_eff = LEN_W'(1);
      end else if (req_len > LEN_W'(MAX_BYTES)) begin
         len_eff = LEN_W'(MAX_BYTES);
      end
      dbits_load = BIT_W'({len_eff, 3'b000});
      bits_load  = dbits_load + (req_long ? BIT_W'(LONG_HDR_W) : BIT_W'(SHORT_HDR_W));
   end

   // Frame image, MSB sent first: header, then byte 0, byte 1, ...
   // The data field stays zero for reads so sdi idles low in that phase.
   always_comb begin
      tx_load = '0;
      if (req_long) begin
         tx_load[SR_W-1 -: LONG_HDR_W] = {1'b1, req_addr, req_write, 4'b0000};
         if (req_write) begin
            for (int i = 0; i < MAX_BYTES; i++) begin
               tx_load[SR_W-1-LONG_HDR_W-8*i -: 8] = wr_data[8*i +: 8];
            end
         end
      end else begin
         tx_load[SR_W-1 -: SHORT_HDR_W] = {1'b0, req_addr[5:0], req_write};
         if (req_write) begin
            for (int i = 0; i < MAX_BYTES; i++) begin
               tx_load[SR_W-1-SHORT_HDR_W-8*i -: 8] = wr_data[8*i +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         req_ready <= 1'b0;
         cs        <= 1'b1;
         sck       <= 1'b0;
         sdi       <= 1'b0;
         done      <= 1'b0;
         abort     <= 1'b0;
         rd_data   <= '0;
         tx_sh     <= '0;
         bits_left <= '0;
         data_bits <= '0;
         rx_idx    <= '0;
         rx_bit    <= '0;
         rx_sh     <= '0;
         rx_buf    <= '0;
         gap_cnt   <= '0;
      end else begin
         done  <= 1'b0;
         abort <= 1'b0;
         if (abort_req && clk_en) begin
            state   <= ST_GAP;
            cs      <= 1'b1;
            sck     <= 1'b0;
            sdi     <= 1'b0;
            abort   <= 1'b1;
            gap_cnt <= GAP_W'(CLK_DIV - 1);
         end else begin
            case (state)
               ST_IDLE: begin
                  if (req_valid && req_ready) begin
                     req_ready <= 1'b0;
                     state     <= ST_SETUP;
                     cs        <= 1'b0;
                     sdi       <= tx_load[SR_W-1];
                     tx_sh     <= tx_load;
                     bits_left <= bits_load;
                     data_bits <= dbits_load;
                     rx_idx    <= '0;
                     rx_bit    <= '0;
                     rx_buf    <= rd_data;
                  end else begin
                     req_ready <= 1'b1;
                  end
               end
               ST_SETUP: begin
                  if (fall_tick) begin
                     state <= ST_SHIFT;
                  end
               end
               ST_SHIFT: begin
                  if (rise_tick) begin
                     sck <= 1'b1;
                     // Full duplex: sdo is captured in the data phase of reads and writes.
                     if (bits_left <= data_bits) begin
                        rx_sh  <= {rx_sh[5:0], sdo};
                        rx_bit <= rx_bit + 1'b1;
                        if (rx_bit == 3'd7) begin
                           for (int k = 0; k < MAX_BYTES; k++) begin
                              if (rx_idx == LEN_W'(k)) begin
                                 rx_buf[8*k +: 8] <= {rx_sh, sdo};
                              end
                           end
                           rx_idx <= rx_idx + 1'b1;
                        end
                     end
                  end else if (fall_tick) begin
                     sck       <= 1'b0;
                     tx_sh     <= tx_sh << 1;
                     bits_left <= bits_left - 1'b1;
                     if (bits_left == BIT_W'(1)) begin
                        state <= ST_HOLD;
                        sdi   <= 1'b0;
                     end else begin
                        sdi <= tx_sh[SR_W-2];
                     end
                  end
               end
               ST_HOLD: begin
                  if (rise_tick) begin
                     state   <= ST_GAP;
                     cs      <= 1'b1;
                     rd_data <= rx_buf;
                     done    <= 1'b1;
                     gap_cnt <= GAP_W'(CLK_DIV - 1);
                  end
               end
               ST_GAP: begin
                  if (gap_cnt == '0) begin
                     state     <= ST_IDLE;
                     req_ready <= 1'b1;
                  end else begin
                     gap_cnt <= gap_cnt - 1'b1;
                  end
               end
               default: begin
                  state <= ST_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_rf_spi_burst.sv
// Directed bench for rf_spi_burst with a mode-0 SPI slave model driving sdo.
`timescale 1ns/1ps
module tb_rf_spi_burst;

   localparam int CLK_DIV   = 4;
   localparam int MAX_BYTES = 4;
   localparam int LEN_W     = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid, req_ready, req_long, req_write;
   logic [9:0]  req_addr;
   logic [LEN_W-1:0] req_len;
   logic [31:0] wr_data, rd_data;
   logic        done, abort, intr, sdo, sck, sdi, cs, intr_out, rst_n;

   int n_tests = 0;
   int n_fail  = 0;

   logic        clr = 1'b0;
   logic [63:0] slave_word = '0;
   logic [5:0]  sidx = '0;
   logic [63:0] mosi_sh = '0;
   int n_rise = 0, cs_low = 0, done_cnt = 0, abort_cnt = 0, accepts = 0;
   int frames = 0, hi_run = 0, min_gap = 1000;
   logic prev_cs = 1'b1;

   rf_spi_burst #(
      .CLK_DIV  (CLK_DIV),
      .MAX_BYTES(MAX_BYTES)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_long (req_long),
      .req_write(req_write),
      .req_addr (req_addr),
      .req_len  (req_len),
      .wr_data  (wr_data),
      .rd_data  (rd_data),
      .done     (done),
      .abort    (abort),
      .intr     (intr),
      .sdo      (sdo),
      .sck      (sck),
      .sdi      (sdi),
      .cs       (cs),
      .intr_out (intr_out),
      .rst_n    (rst_n)
   );

   always #5 clk = ~clk;

   // Slave: bit 63 of slave_word goes out first, next bit after each SCK fall.
   assign sdo = slave_word[~sidx];

   always @(negedge sck or posedge cs) begin
      if (cs) sidx <= '0;
      else    sidx <= sidx + 6'd1;
   end

   always @(posedge sck or posedge clr) begin
      if (clr) begin
         n_rise  <= 0;
         mosi_sh <= '0;
      end else begin
         n_rise  <= n_rise + 1;
         mosi_sh <= {mosi_sh[62:0], sdi};
      end
   end

   always @(posedge clk) begin
      if (clr) begin
         cs_low <= 0; done_cnt <= 0; abort_cnt <= 0; accepts <= 0;
         frames <= 0; hi_run <= 0; min_gap <= 1000; prev_cs <= 1'b1;
      end else begin
         if (!cs)                    cs_low    <= cs_low + 1;
         if (done)                   done_cnt  <= done_cnt + 1;
         if (abort)                  abort_cnt <= abort_cnt + 1;
         if (req_valid && req_ready) accepts   <= accepts + 1;
         prev_cs <= cs;
         if (cs) begin
            hi_run <= hi_run + 1;
         end else begin
            hi_run <= 0;
            if (prev_cs) begin
               frames <= frames + 1;
               if (frames > 0 && hi_run < min_gap) min_gap <= hi_run;
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_stats();
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
   endtask

   task automatic start_txn(input logic lng, input logic wr, input logic [9:0] addr,
                            input logic [LEN_W-1:0] len, input logic [31:0] wd);
      for (int i = 0; i < 200 && !req_ready; i++) @(negedge clk);
      chk("ready_before_start", 64'(req_ready), 64'(1));
      req_long  = lng;
      req_write = wr;
      req_addr  = addr;
      req_len   = len;
      wr_data   = wd;
      req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic wait_done(input int target, input string tag);
      for (int i = 0; i < 1000 && done_cnt < target; i++) @(negedge clk);
      chk(tag, 64'(done_cnt >= target), 64'(1));
      for (int i = 0; i < 100 && !req_ready; i++) @(negedge clk);
      @(negedge clk);
   endtask

   task automatic wait_rises(input int n, input string tag);
      for (int i = 0; i < 1000 && n_rise < n; i++) @(negedge clk);
      chk(tag, 64'(n_rise), 64'(n));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      req_valid = 1'b0; req_long = 1'b0; req_write = 1'b0;
      req_addr = '0; req_len = '0; wr_data = '0; intr = 1'b0;
      clear_stats();
      @(negedge clk);
      chk("rst_cs",        64'(cs),        64'(1));
      chk("rst_sck",       64'(sck),       64'(0));
      chk("rst_sdi",       64'(sdi),       64'(0));
      chk("rst_req_ready", 64'(req_ready), 64'(0));
      chk("rst_done",      64'(done),      64'(0));
      chk("rst_abort",     64'(abort),     64'(0));
      chk("rst_rd_data",   64'(rd_data),   64'(0));
      chk("rst_n_low",     64'(rst_n),     64'(0));
      rst = 1'b0;
      #1;
      chk("rst_n_high",    64'(rst_n),     64'(1));
      chk("ready_pre_edge", 64'(req_ready), 64'(0));
      @(negedge clk);
      chk("ready_post_rel", 64'(req_ready), 64'(1));
      intr = 1'b1;
      #1 chk("intr_out_hi", 64'(intr_out), 64'(1));
      intr = 1'b0;
      #1 chk("intr_out_lo", 64'(intr_out), 64'(0));

      // Short write, addr 0x15, one byte 0xA5; slave returns 0x5A in the data phase
      clear_stats();
      slave_word = {8'h00, 8'h5A, 48'h0};
      start_txn(1'b0, 1'b1, 10'h015, 3'd1, 32'h0000_00A5);
      chk("t1_busy_ready", 64'(req_ready), 64'(0));
      chk("t1_cs_active",  64'(cs),        64'(0));
      wait_done(1, "t1_done_seen");
      chk("t1_rises",   64'(n_rise),        64'(16));
      chk("t1_sdi",     64'(mosi_sh[15:0]), 64'h2BA5);
      chk("t1_cs_low",  64'(cs_low),        64'(16*CLK_DIV + CLK_DIV));
      chk("t1_dones",   64'(done_cnt),      64'(1));
      chk("t1_rd_data", 64'(rd_data),       64'h0000_005A);

      // Long read, addr 0x200, two bytes 0x3C then 0xC3
      clear_stats();
      slave_word = {16'h0, 8'h3C, 8'hC3, 32'h0};
      start_txn(1'b1, 1'b0, 10'h200, 3'd2, 32'h0);
      wait_done(1, "t2_done_seen");
      chk("t2_rises",   64'(n_rise),        64'(32));
      chk("t2_sdi",     64'(mosi_sh[31:0]), 64'hC000_0000);
      chk("t2_cs_low",  64'(cs_low),        64'(32*CLK_DIV + CLK_DIV));
      chk("t2_dones",   64'(done_cnt),      64'(1));
      chk("t2_rd_data", 64'(rd_data),       64'h0000_C33C);

      // req_len = 0 behaves as one byte
      clear_stats();
      slave_word = {8'h00, 8'h77, 48'h0};
      start_txn(1'b0, 1'b1, 10'h001, 3'd0, 32'h0000_0033);
      wait_done(1, "t3_done_seen");
      chk("t3_rises",   64'(n_rise),        64'(16));
      chk("t3_sdi",     64'(mosi_sh[15:0]), 64'h0333);
      chk("t3_rd_data", 64'(rd_data),       64'h0000_C377);

      // req_len = MAX_BYTES+3 clamps to MAX_BYTES
      clear_stats();
      slave_word = {16'h0, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 16'h0};
      start_txn(1'b1, 1'b1, 10'h3FF, 3'd7, 32'h4433_2211);
      wait_done(1, "t4_done_seen");
      chk("t4_rises",   64'(n_rise),        64'(48));
      chk("t4_sdi",     64'(mosi_sh[47:0]), 64'hFFF0_1122_3344);
      chk("t4_cs_low",  64'(cs_low),        64'(48*CLK_DIV + CLK_DIV));
      chk("t4_rd_data", 64'(rd_data),       64'hD4C3_B2A1);

      // req_valid held high across two frames
      clear_stats();
      slave_word = '0;
      req_long = 1'b0; req_write = 1'b0; req_addr = 10'h02A; req_len = 3'd1; wr_data = '0;
      req_valid = 1'b1;
      for (int i = 0; i < 2000 && done_cnt < 2; i++) @(negedge clk);
      req_valid = 1'b0;
      chk("t5_two_dones", 64'(done_cnt), 64'(2));
      for (int i = 0; i < 100 && !req_ready; i++) @(negedge clk);
      repeat (3) @(negedge clk);
      chk("t5_accepts",  64'(accepts),             64'(2));
      chk("t5_frames",   64'(frames),              64'(2));
      chk("t5_gap",      64'(min_gap >= CLK_DIV),  64'(1));
      chk("t5_rises",    64'(n_rise),              64'(32));
      chk("t5_sdi",      64'(mosi_sh[31:0]),       64'h5400_5400);
      chk("t5_rd_data",  64'(rd_data),             64'hD4C3_B200);

      // intr high at bit 5 of a short read
      clear_stats();
      slave_word = {8'h00, 8'hFF, 48'h0};
      start_txn(1'b0, 1'b0, 10'h015, 3'd1, 32'h0);
      wait_rises(5, "t6_reach_bit5");
      intr = 1'b1;
      @(negedge clk);
      intr = 1'b0;
`ifdef RF_SPI_INTR_ABORT_EN
      chk("t6_cs_high",  64'(cs),    64'(1));
      chk("t6_sck_low",  64'(sck),   64'(0));
      chk("t6_abort",    64'(abort), 64'(1));
      for (int i = 0; i < 100 && !req_ready; i++) @(negedge clk);
      @(negedge clk);
      chk("t6_ready_back", 64'(req_ready), 64'(1));
      chk("t6_dones",      64'(done_cnt),  64'(0));
      chk("t6_aborts",     64'(abort_cnt), 64'(1));
      chk("t6_rises",      64'(n_rise),    64'(5));
      chk("t6_rd_data",    64'(rd_data),   64'hD4C3_B200);
`else
      chk("t6_cs_active", 64'(cs),    64'(0));
      chk("t6_no_abort",  64'(abort), 64'(0));
      wait_done(1, "t6_done_seen");
      chk("t6_dones",     64'(done_cnt),  64'(1));
      chk("t6_aborts",    64'(abort_cnt), 64'(0));
      chk("t6_rises",     64'(n_rise),    64'(16));
      chk("t6_rd_data",   64'(rd_data),   64'hD4C3_B2FF);
`endif

      // Reset at bit 10 of a long write
      clear_stats();
      slave_word = '0;
      start_txn(1'b1, 1'b1, 10'h155, 3'd2, 32'h0000_BEEF);
      wait_rises(10, "t7_reach_bit10");
      rst = 1'b1;
      #1;
      chk("t7_cs_high",   64'(cs),        64'(1));
      chk("t7_sck_low",   64'(sck),       64'(0));
      chk("t7_ready_low", 64'(req_ready), 64'(0));
      chk("t7_rd_clear",  64'(rd_data),   64'(0));
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1 chk("t7_ready_at_release", 64'(req_ready), 64'(0));
      @(negedge clk);
      chk("t7_ready_after", 64'(req_ready), 64'(1));
      chk("t7_no_done",     64'(done_cnt),  64'(0));
      chk("t7_no_abort",    64'(abort_cnt), 64'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
